// File: rtl/ram_lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 codes, ram mem_ctrl codes, FSM states.
// Latency: n/a (declarations and one combinational helper).
// Backpressure: n/a.
package ram_lsu_pkg;

   // ram mem_ctrl write-width codes; the values line up with funct3[1:0].
   localparam logic [1:0] STORE_B  = 2'b00;
   localparam logic [1:0] STORE_HW = 2'b01;
   localparam logic [1:0] STORE_W  = 2'b10;

   // RV32I load funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // RV32I store funct3
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   // Illegal funct3 or misaligned access; the range check lives in the top
   // because it depends on the ram depth parameter.
   function automatic logic access_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
      logic bad_f3;
      logic misalign;
      if (we)
         bad_f3 = funct3[2] | (funct3[1:0] == 2'b11);
      else
         bad_f3 = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
      misalign = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
                 ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
      return bad_f3 | misalign;
   endfunction

endpackage

// File: rtl/ram_lsu_load_extend.sv
// Load data extractor: picks the byte/halfword/word from a ram word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3 (load type), offset (addr[1:0]), word (raw ram word), result (extended data).
module load_extend
   import ram_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'd0;
      half_sel = 16'd0;
      result   = 32'd0;

      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase

      // Halfword accesses are already known aligned, so offset[1] alone picks the half.
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  result = {24'd0, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  result = {16'd0, half_sel};
         F3_LW:   result = word;
         default: result = 32'd0;
      endcase
   end

endmodule

// File: rtl/ram_lsu.sv
// Load/store initiator between the core memory stage and the ram (registered-read data memory).
// Latency: accept to rsp_valid -- load 3 cycles, store 2, error 1; one request in flight.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
// Ports: clk/rst; req_* request handshake; rsp_* response handshake; mem_* ram port.
module ram_lsu
   import ram_lsu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [1:0]  mem_ctrl,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state, state_nxt;
   logic        we_q, we_nxt;
   logic [2:0]  f3_q, f3_nxt;
   logic        rsp_valid_nxt, rsp_err_nxt, mem_we_nxt;
   logic [31:0] rsp_rdata_nxt, mem_addr_nxt, mem_wdata_nxt;
   logic [1:0]  mem_ctrl_nxt;
   logic [31:0] load_word;
   logic [29:0] word_idx;
   logic        req_bad;

   assign req_ready = (state == IDLE);
   assign word_idx  = req_addr[31:2];
   assign req_bad   = access_err(req_we, req_funct3, req_addr[1:0]) |
                      ((word_idx >> N) != 30'd0);

   // mem_addr is still the load address during WAIT, so its low bits give the lane.
   load_extend u_load_extend (
      .funct3 (f3_q),
      .offset (mem_addr[1:0]),
      .word   (mem_rdata),
      .result (load_word)
   );

   always_comb begin
      state_nxt     = state;
      we_nxt        = we_q;
      f3_nxt        = f3_q;
      rsp_valid_nxt = rsp_valid;
      rsp_err_nxt   = rsp_err;
      rsp_rdata_nxt = rsp_rdata;
      mem_we_nxt    = 1'b0;
      mem_ctrl_nxt  = mem_ctrl;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;

      case (state)
         IDLE: begin
            if (req_valid) begin
               we_nxt = req_we;
               f3_nxt = req_funct3;
               if (req_bad) begin
                  // Rejected without touching the ram port.
                  state_nxt     = RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
                  rsp_rdata_nxt = 32'd0;
               end else begin
                  state_nxt     = ISSUE;
                  mem_we_nxt    = req_we;
                  mem_addr_nxt  = req_addr;
                  mem_wdata_nxt = req_wdata;
                  case (req_funct3[1:0])
                     2'b00:   mem_ctrl_nxt = STORE_B;
                     2'b01:   mem_ctrl_nxt = STORE_HW;
                     default: mem_ctrl_nxt = STORE_W;
                  endcase
               end
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = 32'd0;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b0;
            rsp_rdata_nxt = load_word;
         end
         default: begin
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = 32'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         f3_q      <= 3'd0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'd0;
         mem_we    <= 1'b0;
         mem_ctrl  <= STORE_W;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else begin
         state     <= state_nxt;
         we_q      <= we_nxt;
         f3_q      <= f3_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_err   <= rsp_err_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         mem_we    <= mem_we_nxt;
         mem_ctrl  <= mem_ctrl_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
      end
   end

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu with a behavioural registered-read ram on the mem_* port.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls.
module tb_ram_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_we;
   logic [1:0]  mem_ctrl;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;

   always #5 clk = ~clk;

   ram_lsu #(.N(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_we     (mem_we),
      .mem_ctrl   (mem_ctrl),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Behavioural ram: byte-lane writes, one-cycle registered read.
   logic [31:0] ram_mem [0:255];
   logic [31:0] ram_q;
   assign mem_rdata = ram_q;

   always @(posedge clk) begin
      if (mem_we) begin
         we_cnt <= we_cnt + 1;
         case (mem_ctrl)
            2'b00:   ram_mem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
            2'b01:   ram_mem[mem_addr[9:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
            default: ram_mem[mem_addr[9:2]] <= mem_wdata;
         endcase
      end
      ram_q <= ram_mem[mem_addr[9:2]];
   end

   // One full request/response with rsp_ready held high; lat counts edges from accept.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
      int w;
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hs: ready=%b valid=%b err=%b want 1 0 0", req_ready, rsp_valid, rsp_err);
      end
      n_cmp++;
      if (rsp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", rsp_rdata, mem_addr, mem_wdata);
      end
      n_cmp++;
      if (mem_we !== 1'b0 || mem_ctrl !== 2'b10) begin
         n_bad++;
         $display("FAIL reset_mem: we=%b ctrl=%b want 0 10", mem_we, mem_ctrl);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat; int w0;
      w0 = we_cnt;
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
      n_cmp++;
      if (lat !== 2 || er !== 1'b0 || rd !== 32'd0 || we_cnt - w0 !== 1) begin
         n_bad++;
         $display("FAIL sw_10: lat=%0d err=%b rdata=%h wecyc=%0d want 2 0 0 1", lat, er, rd, we_cnt - w0);
      end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      n_cmp++;
      if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL lw_10: lat=%0d err=%b rdata=%h want 3 0 deadbeef", lat, er, rd);
      end
   endtask

   task automatic test_subword_load();
      logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101};
      logic [31:0] adrs [5] = '{32'h23, 32'h23, 32'h21, 32'h22, 32'h20};
      logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b010, 32'h20, 32'h80FF7F01, rd, er, lat);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat);
         n_cmp++;
         if (rd !== exps[i] || er !== 1'b0 || lat !== 3) begin
            n_bad++;
            $display("FAIL subload_%0d: rdata=%h err=%b lat=%0d want %h 0 3", i, rd, er, lat, exps[i]);
         end
      end
   endtask

   task automatic test_partial_store();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b010, 32'h20, 32'h11223344, rd, er, lat);
      do_req(1'b1, 3'b000, 32'h21, 32'h000000AA, rd, er, lat);
      n_cmp++;
      if (lat !== 2 || er !== 1'b0) begin
         n_bad++;
         $display("FAIL sb_21: lat=%0d err=%b want 2 0", lat, er);
      end
      do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h1122AA44) begin
         n_bad++;
         $display("FAIL sb_readback: rdata=%h want 1122aa44", rd);
      end
      do_req(1'b1, 3'b001, 32'h22, 32'h00005566, rd, er, lat);
      do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h5566AA44) begin
         n_bad++;
         $display("FAIL sh_readback: rdata=%h want 5566aa44", rd);
      end
   endtask

   task automatic test_errors();
      logic        wes  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
      logic [31:0] adrs [4] = '{32'h21, 32'h23, 32'h400, 32'h20};
      logic [31:0] rd; logic er; int lat; int w0;
      for (int i = 0; i < 4; i++) begin
         w0 = we_cnt;
         do_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, rd, er, lat);
         n_cmp++;
         if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || we_cnt !== w0) begin
            n_bad++;
            $display("FAIL err_%0d: err=%b rdata=%h lat=%0d wecyc=%0d want 1 0 1 0",
                     i, er, rd, lat, we_cnt - w0);
         end
      end
      do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h5566AA44 || er !== 1'b0) begin
         n_bad++;
         $display("FAIL err_mem_intact: rdata=%h err=%b want 5566aa44 0", rd, er);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat; int w; int w0;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
      @(posedge clk); #1;
      // A store stays offered for the whole stall and must wait for IDLE.
      req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BADF00D;
      w = 0;
      while (rsp_valid !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      w0 = we_cnt;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_%0d: valid=%b rdata=%h ready=%b want 1 deadbeef 0",
                     i, rsp_valid, rsp_rdata, req_ready);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || we_cnt !== w0) begin
         n_bad++;
         $display("FAIL post_handshake: ready=%b valid=%b wecyc=%0d want 1 0 0", req_ready, rsp_valid, we_cnt - w0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_cmp++;
      if (mem_we !== 1'b1 || req_ready !== 1'b0 || mem_addr !== 32'h40) begin
         n_bad++;
         $display("FAIL late_accept: we=%b ready=%b addr=%h want 1 0 40", mem_we, req_ready, mem_addr);
      end
      w = 0;
      while (rsp_valid !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h0BADF00D) begin
         n_bad++;
         $display("FAIL late_store_readback: rdata=%h want 0badf00d", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; int seen;
      do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, rd, er, lat);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_cmp++;
      if (mem_we !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_issue_we: we=%b want 1", mem_we);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_ctrl !== 2'b10) begin
         n_bad++;
         $display("FAIL rst_async: we=%b valid=%b ready=%b ctrl=%b want 0 0 1 10",
                  mem_we, rsp_valid, req_ready, mem_ctrl);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (rsp_valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL rst_no_rsp: valid cycles=%0d want 0", seen);
      end
      do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hCAFEF00D || lat !== 3) begin
         n_bad++;
         $display("FAIL rst_mem_kept: rdata=%h lat=%0d want cafef00d 3", rd, lat);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
      test_reset();
      test_word();
      test_subword_load();
      test_partial_store();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
